alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 198 +++++++++++++++++++
 tb/tb_alu_pipe.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ============================================================================
// Module   : alu_pipe
// Brief    : Two-stage ARM-style data-processing ALU with NZCV flag register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_pipe #(
    parameter int WIDTH       = 32,
    parameter int FLAG_LD_PRI = 1
) (
    input  logic             nGCLK,
    input  logic             nRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             shift_c,
    input  logic             set_flags,
    input  logic             flush,
    input  logic             flags_ld,
    input  logic [3:0]       flags_din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_we,
    output logic [3:0]       flags
);

    localparam logic [3:0] c_AND = 4'h0;
    localparam logic [3:0] c_EOR = 4'h1;
    localparam logic [3:0] c_SUB = 4'h2;
    localparam logic [3:0] c_RSB = 4'h3;
    localparam logic [3:0] c_ADD = 4'h4;
    localparam logic [3:0] c_ADC = 4'h5;
    localparam logic [3:0] c_SBC = 4'h6;
    localparam logic [3:0] c_RSC = 4'h7;
    localparam logic [3:0] c_TST = 4'h8;
    localparam logic [3:0] c_TEQ = 4'h9;
    localparam logic [3:0] c_CMP = 4'hA;
    localparam logic [3:0] c_CMN = 4'hB;
    localparam logic [3:0] c_ORR = 4'hC;
    localparam logic [3:0] c_MOV = 4'hD;
    localparam logic [3:0] c_BIC = 4'hE;
    localparam logic [3:0] c_MVN = 4'hF;

    // Stage A (input register)
    logic             a_valid_q, a_valid_d;
    logic [3:0]       a_ctrl_q,  a_ctrl_d;
    logic [WIDTH-1:0] a_op1_q,   a_op1_d;
    logic [WIDTH-1:0] a_op2_q,   a_op2_d;
    logic             a_shc_q,   a_shc_d;
    logic             a_s_q,     a_s_d;

    // Stage B (execute/output register) and flags
    logic             b_valid_q, b_valid_d;
    logic [WIDTH-1:0] result_q,  result_d;
    logic             we_q,      we_d;
    logic [3:0]       flags_q,   flags_d;

    logic             w_b_adv;
    logic             w_accept;
    logic             w_exec;
    logic             w_alu_wr;

    logic             w_is_arith;
    logic             w_inv_a;
    logic             w_inv_b;
    logic             w_cin;
    logic [WIDTH-1:0] w_add_a;
    logic [WIDTH-1:0] w_add_b;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_logic_res;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_we;
    logic [3:0]       w_alu_flags;

    // Execute datapath, operating on the contents of stage A
    always_comb begin
        w_inv_a    = (a_ctrl_q == c_RSB) || (a_ctrl_q == c_RSC);
        w_inv_b    = (a_ctrl_q == c_SUB) || (a_ctrl_q == c_SBC) || (a_ctrl_q == c_CMP);
        w_add_a    = w_inv_a ? ~a_op1_q : a_op1_q;
        w_add_b    = w_inv_b ? ~a_op2_q : a_op2_q;
        w_is_arith = 1'b0;
        w_cin      = 1'b0;
        unique case (a_ctrl_q)
            c_ADD, c_CMN:        begin w_is_arith = 1'b1; w_cin = 1'b0;       end
            c_SUB, c_RSB, c_CMP: begin w_is_arith = 1'b1; w_cin = 1'b1;       end
            c_ADC, c_SBC, c_RSC: begin w_is_arith = 1'b1; w_cin = flags_q[1]; end
            default:             begin w_is_arith = 1'b0; w_cin = 1'b0;       end
        endcase
        w_sum = {1'b0, w_add_a} + {1'b0, w_add_b} + {{WIDTH{1'b0}}, w_cin};

        unique case (a_ctrl_q)
            c_AND, c_TST: w_logic_res = a_op1_q & a_op2_q;
            c_EOR, c_TEQ: w_logic_res = a_op1_q ^ a_op2_q;
            c_ORR:        w_logic_res = a_op1_q | a_op2_q;
            c_MOV:        w_logic_res = a_op2_q;
            c_BIC:        w_logic_res = a_op1_q & ~a_op2_q;
            c_MVN:        w_logic_res = ~a_op2_q;
            default:      w_logic_res = '0;
        endcase

        w_alu_res      = w_is_arith ? w_sum[WIDTH-1:0] : w_logic_res;
        w_alu_we       = (a_ctrl_q[3:2] != 2'b10);
        w_alu_flags[3] = w_alu_res[WIDTH-1];
        w_alu_flags[2] = (w_alu_res == '0);
        w_alu_flags[1] = w_is_arith ? w_sum[WIDTH] : a_shc_q;
        w_alu_flags[0] = w_is_arith ? (w_add_a[WIDTH-1] ^ w_add_b[WIDTH-1] ^
                                       w_sum[WIDTH-1] ^ w_sum[WIDTH])
                                    : flags_q[0];
    end

    // Handshake and next-state; flush wins over acceptance and execution
    always_comb begin
        w_b_adv  = !b_valid_q || out_ready;
        in_ready = !a_valid_q || w_b_adv;
        w_accept = in_valid && in_ready;
        w_exec   = a_valid_q && w_b_adv && !flush;
        w_alu_wr = w_exec && a_s_q;

        a_valid_d = a_valid_q;
        a_ctrl_d  = a_ctrl_q;
        a_op1_d   = a_op1_q;
        a_op2_d   = a_op2_q;
        a_shc_d   = a_shc_q;
        a_s_d     = a_s_q;
        if (flush) begin
            a_valid_d = 1'b0;
        end else if (w_accept) begin
            a_valid_d = 1'b1;
            a_ctrl_d  = control;
            a_op1_d   = op1;
            a_op2_d   = op2;
            a_shc_d   = shift_c;
            a_s_d     = set_flags;
        end else if (w_b_adv) begin
            a_valid_d = 1'b0;
        end

        b_valid_d = b_valid_q;
        result_d  = result_q;
        we_d      = we_q;
        if (flush) begin
            b_valid_d = 1'b0;
        end else if (w_b_adv) begin
            b_valid_d = a_valid_q;
            if (a_valid_q) begin
                result_d = w_alu_res;
                we_d     = w_alu_we;
            end
        end

        flags_d = flags_q;
        if (w_alu_wr && flags_ld) begin
            flags_d = (FLAG_LD_PRI != 0) ? flags_din : w_alu_flags;
        end else if (w_alu_wr) begin
            flags_d = w_alu_flags;
        end else if (flags_ld) begin
            flags_d = flags_din;
        end
    end

    always_ff @(posedge nGCLK or negedge nRESET) begin
        if (!nRESET) begin
            a_valid_q <= 1'b0;
            a_ctrl_q  <= '0;
            a_op1_q   <= '0;
            a_op2_q   <= '0;
            a_shc_q   <= 1'b0;
            a_s_q     <= 1'b0;
            b_valid_q <= 1'b0;
            result_q  <= '0;
            we_q      <= 1'b0;
            flags_q   <= 4'b0000;
        end else begin
            a_valid_q <= a_valid_d;
            a_ctrl_q  <= a_ctrl_d;
            a_op1_q   <= a_op1_d;
            a_op2_q   <= a_op2_d;
            a_shc_q   <= a_shc_d;
            a_s_q     <= a_s_d;
            b_valid_q <= b_valid_d;
            result_q  <= result_d;
            we_q      <= we_d;
            flags_q   <= flags_d;
        end
    end

    assign out_valid = b_valid_q;
    assign result    = result_q;
    assign result_we = we_q;
    assign flags     = flags_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_pipe.sv
// ============================================================================
// Module   : tb_alu_pipe
// Brief    : Self-checking bench for alu_pipe against an arithmetic reference.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        in_valid, in_ready, shift_c, set_flags, flush, flags_ld;
    logic [3:0]  control, flags_din, flags;
    logic [31:0] op1, op2, result;
    logic        out_valid, out_ready, result_we;

    logic        in_valid16, in_ready16, out_valid16, result_we16;
    logic [15:0] op1_16, op2_16, result16;
    logic [3:0]  flags16;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32), .FLAG_LD_PRI(1)) u_dut (
        .nGCLK(clk), .nRESET(nRESET), .in_valid(in_valid), .in_ready(in_ready),
        .control(control), .op1(op1), .op2(op2), .shift_c(shift_c),
        .set_flags(set_flags), .flush(flush), .flags_ld(flags_ld),
        .flags_din(flags_din), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .result_we(result_we), .flags(flags)
    );

    alu_pipe #(.WIDTH(16), .FLAG_LD_PRI(1)) u_dut16 (
        .nGCLK(clk), .nRESET(nRESET), .in_valid(in_valid16), .in_ready(in_ready16),
        .control(4'h4), .op1(op1_16), .op2(op2_16), .shift_c(1'b0),
        .set_flags(1'b1), .flush(1'b0), .flags_ld(1'b0),
        .flags_din(4'b0000), .out_valid(out_valid16), .out_ready(1'b1),
        .result(result16), .result_we(result_we16), .flags(flags16)
    );

    typedef struct {
        logic [31:0] r;
        logic        we;
        logic [3:0]  f;
    } exp_t;

    exp_t       q[$];
    logic [3:0] mf;
    int         n_chk  = 0;
    int         n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: ARM semantics via wide signed/unsigned arithmetic
    function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                   input logic sc, input logic s, input logic [3:0] fin);
        exp_t   e;
        longint ua, ub, sa, sb, u, sv, bw;
        logic   arith, co, v;
        logic [31:0] r;
        ua = longint'(a);
        ub = longint'(b);
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bw = fin[1] ? 0 : 1;
        arith = 1'b1; u = 0; sv = 0; co = 1'b0; r = '0;
        case (c)
            4'h4, 4'hB: begin u = ua + ub;             sv = sa + sb;             co = u[32];          end
            4'h5:       begin u = ua + ub + (1 - bw);  sv = sa + sb + (1 - bw);  co = u[32];          end
            4'h2, 4'hA: begin u = ua - ub;             sv = sa - sb;             co = (ua >= ub);      end
            4'h6:       begin u = ua - ub - bw;        sv = sa - sb - bw;        co = (ua >= ub + bw); end
            4'h3:       begin u = ub - ua;             sv = sb - sa;             co = (ub >= ua);      end
            4'h7:       begin u = ub - ua - bw;        sv = sb - sa - bw;        co = (ub >= ua + bw); end
            default:    arith = 1'b0;
        endcase
        if (arith) begin
            r = u[31:0];
            v = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        end else begin
            case (c)
                4'h0, 4'h8: r = a & b;
                4'h1, 4'h9: r = a ^ b;
                4'hC:       r = a | b;
                4'hD:       r = b;
                4'hE:       r = a & ~b;
                default:    r = ~b;
            endcase
            co = sc;
            v  = fin[0];
        end
        e.r  = r;
        e.we = !(c inside {4'h8, 4'h9, 4'hA, 4'hB});
        e.f  = s ? {r[31], (r == 32'd0), co, v} : fin;
        return e;
    endfunction

    // One clock: drive, check presented output, update scoreboard, advance
    task automatic cyc(input logic iv, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic sc, input logic s, input logic ordy,
                       input logic fl = 1'b0, input logic ld = 1'b0, input logic [3:0] din = 4'b0);
        exp_t e;
        in_valid = iv; control = c; op1 = a; op2 = b; shift_c = sc; set_flags = s;
        out_ready = ordy; flush = fl; flags_ld = ld; flags_din = din;
        #1;
        check("in_ready", in_ready, (q.size() < 2) || ordy);
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", out_valid, 1'b0);
            end else begin
                check("result", result, q[0].r);
                check("result_we", result_we, q[0].we);
                check("flags", flags, q[0].f);
                if (ordy && !fl) void'(q.pop_front());
            end
        end
        if (fl) begin
            if (q.size() == 2) mf = q[0].f;
            q.delete();
        end else if (iv && in_ready) begin
            e = model(c, a, b, sc, s, mf);
            q.push_back(e);
            mf = e.f;
        end
        if (ld) mf = din;
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cyc(1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, ordy);
    endtask

    task automatic drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (q.size() == 0 && !out_valid) break;
            idle(1'b1);
        end
        check("drain_queue_empty", q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] saved_f;
        nRESET = 1'b1; mf = 4'b0000;
        in_valid = 0; control = 0; op1 = 0; op2 = 0; shift_c = 0; set_flags = 0;
        out_ready = 0; flush = 0; flags_ld = 0; flags_din = 0;
        in_valid16 = 0; op1_16 = 0; op2_16 = 0;
        #2 nRESET = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_result", result, 32'h0);
        check("rst_result_we", result_we, 1'b0);
        check("rst_flags", flags, 4'b0000);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid16", out_valid16, 1'b0);
        @(negedge clk);
        @(negedge clk);
        nRESET = 1'b1;

        // 16-bit signed overflow into the sign bit
        in_valid16 = 1'b1; op1_16 = 16'h7FFF; op2_16 = 16'h0001;
        #1 check("w16_in_ready", in_ready16, 1'b1);
        @(negedge clk);
        in_valid16 = 1'b0;
        check("w16_lat_edge1", out_valid16, 1'b0);
        @(negedge clk);
        check("w16_lat_edge2", out_valid16, 1'b1);
        check("w16_result", result16, 16'h8000);
        check("w16_nzcv", flags16, 4'b1001);

        // ADD wrap to zero, with latency
        cyc(1, 4'h4, 32'hFFFF_FFFF, 32'h1, 0, 1, 1);
        check("add_lat_edge1", out_valid, 1'b0);
        idle(1'b1);
        check("add_lat_edge2", out_valid, 1'b1);
        check("add_result", result, 32'h0);
        check("add_nzcv", flags, 4'b0110);
        drain(10);

        // CMP signed overflow, no writeback
        cyc(1, 4'hA, 32'h8000_0000, 32'h1, 0, 1, 1);
        idle(1'b1);
        check("cmp_result_we", result_we, 1'b0);
        check("cmp_result", result, 32'h7FFF_FFFF);
        check("cmp_nzcv", flags, 4'b0011);
        drain(10);

        // Back-to-back ADD then ADC consuming its carry
        cyc(1, 4'h4, 32'hFFFF_FFFF, 32'h1, 0, 1, 1);
        cyc(1, 4'h5, 32'h0, 32'h0, 0, 1, 1);
        idle(1'b1);
        check("adc_result", result, 32'h1);
        check("adc_nzcv", flags, 4'b0000);
        drain(10);

        // Backpressure: three ops offered with out_ready low for 3 cycles
        cyc(1, 4'h4, 32'd10, 32'd1, 0, 0, 0);
        cyc(1, 4'h2, 32'd20, 32'd2, 0, 0, 0);
        cyc(1, 4'hC, 32'h30, 32'h3, 0, 0, 0);
        check("bp_in_ready_low", in_ready, 1'b0);
        check("bp_held_result", result, 32'd11);
        cyc(1, 4'hC, 32'h30, 32'h3, 0, 0, 1);
        check("bp_queue_depth", q.size(), 2);
        drain(10);

        // External flag load alone, then coinciding with an ALU write
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 1'b0, 1'b1, 4'b1010);
        check("ld_flags", flags, 4'b1010);
        cyc(1, 4'h4, 32'd1, 32'd1, 0, 1, 1);
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 0, 1, 1'b0, 1'b1, 4'b0101);
        if (q.size() == 1) q[0].f = 4'b0101;
        check("ld_pri_flags", flags, 4'b0101);
        check("ld_pri_result", result, 32'd2);
        drain(10);

        // Flush with two ops in flight
        cyc(1, 4'h4, 32'hFFFF_FFFF, 32'h1, 0, 1, 0);
        cyc(1, 4'h2, 32'h1, 32'h2, 0, 1, 0);
        saved_f = mf;
        cyc(0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 1'b1);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_flags_older_op", flags, 4'b0110);
        check("flush_model_reverted", (mf != saved_f), 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        cyc(1, 4'hD, 32'h0, 32'h1234_5678, 0, 1, 1);
        drain(10);

        // Asynchronous reset with two ops in flight
        cyc(1, 4'h4, 32'd5, 32'd6, 0, 1, 0);
        cyc(1, 4'hF, 32'd0, 32'd0, 1, 1, 0);
        in_valid = 1'b0;
        nRESET = 1'b0;
        #1;
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_result", result, 32'h0);
        check("mrst_result_we", result_we, 1'b0);
        check("mrst_flags", flags, 4'b0000);
        check("mrst_in_ready", in_ready, 1'b1);
        q.delete();
        mf = 4'b0000;
        @(negedge clk);
        nRESET = 1'b1;
        for (int i = 0; i < 3; i++) idle(1'b1);
        cyc(1, 4'h3, 32'd1, 32'd0, 0, 1, 1);
        drain(10);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: a = 32'hFFFF_FFFF;
                1: b = 32'h8000_0000;
                2: a = b;
                default: ;
            endcase
            cyc(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), a, b,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) != 0));
        end
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
